// File: rtl/rv32i_fetch_pkg.sv
// Shared types and constants for the RV32I fetch unit.
//   fetch_state_e : fetch FSM state encoding
//   RV32I_NOP     : instruction presented while nothing has been fetched (addi x0, x0, 0)
//   PC_STEP       : sequential PC increment
//   PC_ALIGN_MASK : clears the low two bits of a branch target
package rv32i_fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_TRAP  = 3'd4
    } fetch_state_e;

    localparam logic [31:0] RV32I_NOP     = 32'h0000_0013;
    localparam logic [31:0] PC_STEP       = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_reg_rv32i.sv
// Architectural PC register with load enable and the PC+4 adder.
// Ports:
//   clock, reset_n : system clock (rising edge), asynchronous active-low reset
//   load           : capture pc_next on the next rising edge
//   pc_next        : value to load
//   pc             : current PC (RESET_PC while in reset)
//   pc_new         : pc + 4, wrapping modulo 2^32
module pc_reg_rv32i
    import rv32i_fetch_pkg::*;
#(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            load,
    input  logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_new
);

    logic [XLEN-1:0] pc_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RESET_PC;
        end else if (load) begin
            pc_q <= pc_next;
        end
    end

    assign pc     = pc_q;
    assign pc_new = pc_q + PC_STEP;

endmodule

// File: rtl/fetch_unit_rv32i.sv
// RV32I fetch unit: holds the PC, fetches one instruction at a time over a
// valid/ready request + valid response interface, and holds the instruction
// for decode until the core retires it with pc_load.
// Ports:
//   clock, reset_n                 : clock (rising edge), asynchronous active-low reset
//   PCin, pc_load                  : next PC from the brancher and its retire strobe
//   PCnew                          : pc + 4 back to the brancher
//   pc                             : current PC
//   imem_req_valid/ready, imem_addr: fetch request channel (address = pc)
//   imem_rsp_valid, imem_rsp_data  : fetch response channel
//   instr, instr_valid             : held instruction to decode/CU
//   misalign                       : misaligned-target flag (only with FETCH_MISALIGN_TRAP_EN)
// Build option FETCH_MISALIGN_TRAP_EN: a misaligned pc_load target enters a
// trap state that only reset leaves; otherwise target low bits are cleared.
module fetch_unit_rv32i
    import rv32i_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [XLEN-1:0] PCin,
    input  logic            pc_load,
    output logic [XLEN-1:0] PCnew,
    output logic [XLEN-1:0] pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            misalign,
`endif
    output logic [XLEN-1:0] instr,
    output logic            instr_valid
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            pc_load_en;
    logic [XLEN-1:0] pc_next;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misalign_q, misalign_d;
`endif

    pc_reg_rv32i #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (pc_load_en),
        .pc_next (pc_next),
        .pc      (pc),
        .pc_new  (PCnew)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            instr_q       <= RV32I_NOP;
            instr_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q    <= misalign_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        pc_load_en    = 1'b0;
        pc_next       = PCin & PC_ALIGN_MASK;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d    = misalign_q;
`endif
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    instr_d       = imem_rsp_data;
                    instr_valid_d = 1'b1;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                // A response arriving alongside pc_load is stale and dropped.
                if (pc_load) begin
                    pc_load_en    = 1'b1;
                    instr_valid_d = 1'b0;
                    state_d       = S_FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (PCin[1:0] != 2'b00) begin
                        pc_next    = PCin;
                        misalign_d = 1'b1;
                        state_d    = S_TRAP;
                    end
`endif
                end
            end
            S_TRAP: begin
`ifdef FETCH_MISALIGN_TRAP_EN
                state_d = S_TRAP;
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req_valid = (state_q == S_FETCH);
    assign imem_addr      = pc;
    assign instr          = instr_q;
    assign instr_valid    = instr_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign       = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_unit_rv32i.sv
// Self-checking bench for fetch_unit_rv32i: directed scenarios followed by a
// randomized run against a transaction-level model (expected PC and held word).
module tb_fetch_unit_rv32i;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock;
    logic        reset_n;
    logic [31:0] PCin;
    logic        pc_load;
    logic [31:0] PCnew;
    logic [31:0] pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr;
    logic        instr_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int checks = 0;
    int errors = 0;

    fetch_unit_rv32i #(
        .RESET_PC (32'h0000_0000),
        .XLEN     (32)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .PCin           (PCin),
        .pc_load        (pc_load),
        .PCnew          (PCnew),
        .pc             (pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign       (misalign),
`endif
        .instr          (instr),
        .instr_valid    (instr_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Outputs are sampled and inputs driven at the falling edge.
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic quiet_inputs();
        PCin = 32'h0; pc_load = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        quiet_inputs();
        repeat (3) tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc, 32'h0); end
        checks++; if (instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h exp %h", instr, NOP); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b exp 0", instr_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b exp 0", imem_req_valid); end
        checks++; if (PCnew !== 32'h4) begin errors++; $display("FAIL reset_pcnew: got %h exp %h", PCnew, 32'h4); end
`ifdef FETCH_MISALIGN_TRAP_EN
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b exp 0", misalign); end
`endif
        reset_n = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b exp 1", imem_req_valid); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_req_addr: got %h exp %h", imem_addr, 32'h0); end
    endtask

    // Starts in the fetch state at pc 0 with ready already high.
    task automatic test_basic_and_branch();
        tick();
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL wait_req_valid: got %b exp 0", imem_req_valid); end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00A0_0093;
        tick();
        imem_rsp_valid = 1'b0;
        checks++; if (instr !== 32'h00A0_0093) begin errors++; $display("FAIL basic_instr: got %h exp %h", instr, 32'h00A0_0093); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_instr_valid: got %b exp 1", instr_valid); end
        checks++; if (PCnew !== 32'h4) begin errors++; $display("FAIL basic_pcnew: got %h exp %h", PCnew, 32'h4); end
        PCin = 32'h0000_1100; pc_load = 1'b1; imem_req_ready = 1'b0;
        tick();
        pc_load = 1'b0;
        checks++; if (pc !== 32'h1100) begin errors++; $display("FAIL branch_pc: got %h exp %h", pc, 32'h1100); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL branch_valid_drop: got %b exp 0", instr_valid); end
        checks++; if (imem_addr !== 32'h1100) begin errors++; $display("FAIL branch_addr: got %h exp %h", imem_addr, 32'h1100); end
        checks++; if (PCnew !== 32'h1104) begin errors++; $display("FAIL branch_pcnew: got %h exp %h", PCnew, 32'h1104); end
    endtask

    // Starts in the fetch state at 0x1100.
    task automatic test_stall_and_ignored();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL stall_req_valid[%0d]: got %b exp 1", i, imem_req_valid); end
            checks++; if (imem_addr !== 32'h1100) begin errors++; $display("FAIL stall_addr[%0d]: got %h exp %h", i, imem_addr, 32'h1100); end
        end
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
        tick();
        imem_req_ready = 1'b0;
        checks++; if (instr !== 32'h00A0_0093) begin errors++; $display("FAIL stall_rsp_ignored: got %h exp %h", instr, 32'h00A0_0093); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stall_valid: got %b exp 0", instr_valid); end
        // In the wait state: pc_load must be ignored.
        pc_load = 1'b1; PCin = 32'h0000_2000;
        tick();
        pc_load = 1'b0;
        checks++; if (pc !== 32'h1100) begin errors++; $display("FAIL wait_pc_load_ignored: got %h exp %h", pc, 32'h1100); end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0040_0113;
        tick();
        imem_rsp_valid = 1'b0;
        checks++; if (instr !== 32'h0040_0113) begin errors++; $display("FAIL wait_instr: got %h exp %h", instr, 32'h0040_0113); end
        PCin = 32'hFFFF_FFFC; pc_load = 1'b1;
        tick();
        pc_load = 1'b0;
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h exp %h", pc, 32'hFFFF_FFFC); end
        checks++; if (PCnew !== 32'h0) begin errors++; $display("FAIL wrap_pcnew: got %h exp %h", PCnew, 32'h0); end
    endtask

    // Starts in the fetch state at 0xFFFFFFFC.
    task automatic test_reset_in_wait();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL midreset_pc: got %h exp %h", pc, 32'h0); end
        checks++; if (instr !== NOP) begin errors++; $display("FAIL midreset_instr: got %h exp %h", instr, NOP); end
        tick();
        reset_n = 1'b1;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
        tick();
        imem_rsp_valid = 1'b0;
        checks++; if (instr !== NOP) begin errors++; $display("FAIL midreset_rsp_dropped: got %h exp %h", instr, NOP); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b exp 0", instr_valid); end
        checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL refetch_valid: got %b exp 1", imem_req_valid); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL refetch_addr: got %h exp %h", imem_addr, 32'h0); end
    endtask

    // Starts in the fetch state at 0; ends in the fetch state at 0 after a reset.
    task automatic test_misalign();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0063;
        tick();
        imem_rsp_valid = 1'b0;
        PCin = 32'h0000_1302; pc_load = 1'b1;
        tick();
        pc_load = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign_flag: got %b exp 1", misalign); end
        checks++; if (pc !== 32'h1302) begin errors++; $display("FAIL misalign_pc: got %h exp %h", pc, 32'h1302); end
        imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL trap_no_req[%0d]: got %b exp 0", i, imem_req_valid); end
            tick();
        end
`else
        checks++; if (pc !== 32'h1300) begin errors++; $display("FAIL mask_pc: got %h exp %h", pc, 32'h1300); end
        checks++; if (imem_addr !== 32'h1300) begin errors++; $display("FAIL mask_addr: got %h exp %h", imem_addr, 32'h1300); end
`endif
        reset_n = 1'b0;
        quiet_inputs();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Transaction-level model: each fetch must request the expected PC, hold
    // the returned word, and the next PC is the aligned retire target.
    task automatic test_random();
        logic [31:0] model_pc;
        logic [31:0] word;
        logic [31:0] target;
        model_pc = 32'h0;
        for (int t = 0; t < 40; t++) begin
            for (int w = int'($urandom_range(0, 3)); w > 0; w--) begin
                checks++; if (imem_req_valid !== 1'b1 || imem_addr !== model_pc) begin
                    errors++; $display("FAIL rnd_req[%0d]: got v=%b a=%h exp v=1 a=%h", t, imem_req_valid, imem_addr, model_pc);
                end
                imem_req_ready = 1'b0;
                imem_rsp_valid = 1'($urandom); imem_rsp_data = $urandom;
                pc_load = 1'($urandom); PCin = $urandom;
                tick();
            end
            checks++; if (imem_req_valid !== 1'b1 || imem_addr !== model_pc) begin
                errors++; $display("FAIL rnd_accept[%0d]: got v=%b a=%h exp v=1 a=%h", t, imem_req_valid, imem_addr, model_pc);
            end
            imem_req_ready = 1'b1;
            imem_rsp_valid = 1'($urandom); imem_rsp_data = $urandom;
            pc_load = 1'($urandom); PCin = $urandom;
            tick();
            for (int d = int'($urandom_range(0, 3)); d > 0; d--) begin
                checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
                    errors++; $display("FAIL rnd_wait[%0d]: got req=%b iv=%b exp 0 0", t, imem_req_valid, instr_valid);
                end
                imem_req_ready = 1'($urandom); imem_rsp_valid = 1'b0;
                pc_load = 1'($urandom); PCin = $urandom;
                tick();
            end
            word = $urandom;
            imem_rsp_valid = 1'b1; imem_rsp_data = word;
            imem_req_ready = 1'($urandom); pc_load = 1'($urandom); PCin = $urandom;
            tick();
            for (int h = int'($urandom_range(0, 2)); h >= 0; h--) begin
                checks++; if (instr_valid !== 1'b1 || instr !== word) begin
                    errors++; $display("FAIL rnd_hold[%0d]: got iv=%b i=%h exp 1 %h", t, instr_valid, instr, word);
                end
                checks++; if (pc !== model_pc || PCnew !== model_pc + 32'd4) begin
                    errors++; $display("FAIL rnd_pc[%0d]: got pc=%h new=%h exp %h %h", t, pc, PCnew, model_pc, model_pc + 32'd4);
                end
                imem_rsp_valid = 1'($urandom); imem_rsp_data = $urandom;
                imem_req_ready = 1'($urandom); pc_load = 1'b0;
                tick();
            end
            target = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            target = target & 32'hFFFF_FFFC;
`endif
            PCin = target; pc_load = 1'b1;
            imem_rsp_valid = 1'($urandom); imem_rsp_data = $urandom; imem_req_ready = 1'($urandom);
            tick();
            model_pc = {target[31:2], 2'b00};
            pc_load = 1'b0; imem_rsp_valid = 1'b0;
            checks++; if (instr_valid !== 1'b0 || pc !== model_pc) begin
                errors++; $display("FAIL rnd_retire[%0d]: got iv=%b pc=%h exp 0 %h", t, instr_valid, pc, model_pc);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        quiet_inputs();
        test_reset();
        test_basic_and_branch();
        test_stall_and_ignored();
        test_reset_in_wait();
        test_misalign();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
